// File: rtl/network_div_seq_27s_11ns_16s.sv
// Restoring signed/unsigned divider: 27s / 11u -> 16s saturated quotient, 12s remainder.
// Latency: done pulses after enabled edge DIVIDEND_W+1 from the accepted start, every time.
// Backpressure: ce=0 freezes everything; start is ignored outside IDLE. NETWORK_DIV_ROUND_EN selects round-half-away.
module network_div_seq_27s_11ns_16s #(
    parameter int DIVIDEND_W = 27,
    parameter int DIVISOR_W  = 11,
    parameter int QUOT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W:0]    remainder,
    output logic                  div_zero,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W:0] POS_MAX_MAG = (DIVIDEND_W+1)'((1 << (QUOT_W-1)) - 1);
    localparam logic [DIVIDEND_W:0] NEG_MAX_MAG = (DIVIDEND_W+1)'(1 << (QUOT_W-1));
    localparam logic [QUOT_W-1:0]   Q_MAX       = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]   Q_MIN       = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0]  dq_q;
    logic [DIVISOR_W:0]     rem_q;
    logic [DIVISOR_W-1:0]   dvs_q;
    logic                   neg_q;

    logic [DIVISOR_W:0]     shifted;
    logic [DIVISOR_W:0]     trial;
    logic                   qbit;
    logic [DIVISOR_W:0]     rem_nxt;

    logic                   round_up;
    logic [DIVIDEND_W:0]    mag;
    logic                   sat;
    logic [QUOT_W-1:0]      q_lo;
    logic [QUOT_W-1:0]      q_fin;
    logic [DIVISOR_W:0]     rem_fin;

    always_comb begin
        shifted = {rem_q[DIVISOR_W-1:0], dq_q[DIVIDEND_W-1]};
        qbit    = (shifted >= {1'b0, dvs_q});
        trial   = shifted - {1'b0, dvs_q};
        rem_nxt = qbit ? trial : shifted;
    end

    always_comb begin
`ifdef NETWORK_DIV_ROUND_EN
        round_up = ({rem_q, 1'b0} >= {2'b00, dvs_q});
`else
        round_up = 1'b0;
`endif
        mag   = {1'b0, dq_q} + (DIVIDEND_W+1)'(round_up);
        sat   = neg_q ? (mag > NEG_MAX_MAG) : (mag > POS_MAX_MAG);
        q_lo  = neg_q ? -mag[QUOT_W-1:0] : mag[QUOT_W-1:0];
        q_fin = q_lo;
        if (sat) begin
            q_fin = neg_q ? Q_MIN : Q_MAX;
        end
        rem_fin = neg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_SIGN;
            S_SIGN: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // -2^(W-1) negates to 2^(W-1), which is exact as an unsigned W-bit value.
                        dq_q  <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
                        neg_q <= dividend[DIVIDEND_W-1];
                        dvs_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= CNT_W'(DIVIDEND_W - 1);
                        busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    dq_q  <= {dq_q[DIVIDEND_W-2:0], qbit};
                    rem_q <= rem_nxt;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SIGN: begin
                    done <= 1'b1;
                    if (dvs_q == '0) begin
                        quotient  <= neg_q ? Q_MIN : Q_MAX;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                    end else begin
                        quotient  <= q_fin;
                        remainder <= rem_fin;
                        div_zero  <= 1'b0;
                        overflow  <= sat;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/network_div_seq_27s_11ns_16s.md
Name: network_div_seq_27s_11ns_16s

Overview:
- Sequential signed/unsigned divider: 27-bit signed dividend by 11-bit unsigned divisor, producing a 16-bit signed quotient and a 12-bit signed remainder.
- Inverse of the 16s×11ns→27 multiply path. Used in the network datapath to rescale accumulated 27-bit products back to 16-bit activations when the scale factor is not a power of two.
- Restoring algorithm, one quotient bit per enabled cycle, start/busy/done handshake, global ce stall as in the rest of the pipeline.

Parameters:
- DIVIDEND_W, 27: dividend width, signed.
- DIVISOR_W, 11: divisor width, unsigned.
- QUOT_W, 16: quotient output width, signed, saturating.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (asserted when 0)
- ce  in  1  clock enable; when 0 all state and outputs hold
- start  in  1  request; sampled only in IDLE with ce=1
- dividend  in  DIVIDEND_W  signed dividend, captured on accepted start
- divisor  in  DIVISOR_W  unsigned divisor, captured on accepted start
- busy  out  1  high from the cycle after accept until done is cleared
- done  out  1  one-ce-cycle result-valid pulse
- quotient  out  QUOT_W  signed quotient, saturated
- remainder  out  DIVISOR_W+1  signed remainder
- div_zero  out  1  divisor was 0; valid with done
- overflow  out  1  quotient saturated; valid with done

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, quotient, remainder, div_zero, overflow = 0; iteration counter = 0.
- Every register updates only on edges where ce=1. ce=0 freezes state, counter, and all outputs, including a pending done pulse.
- FSM states:
  - IDLE: start=1 & ce=1 captures operand magnitudes and signs, sets busy=1, counter=DIVIDEND_W-1, next state CALC.
  - CALC: shifts the partial remainder left 1 and brings in the next dividend magnitude bit, MSB first. Trial-subtracts the divisor; if the result is ≥0, keeps it and sets the quotient bit to 1. After counter=0, next state SIGN; otherwise counter decrements.
  - SIGN: applies signs, saturation, and the zero-divisor rule. Registers the outputs, sets done=1, next state DONE.
  - DONE: done=0, busy=0, next state IDLE. Outputs hold until the next SIGN.
- Latency is constant: start accepted at enabled edge 0, done high after enabled edge DIVIDEND_W+1 (28 by default), low after edge DIVIDEND_W+2. The next start can be accepted at the edge after done clears.
- start while not IDLE is ignored: no queueing, no error.
- Arithmetic:
  - Quotient truncates toward zero. Sign is sign(dividend) (divisor is non-negative).
  - Remainder carries the sign of the dividend, |remainder| < divisor, and dividend = q*divisor + r holds when no saturation occurs.
  - Internal quotient magnitude is DIVIDEND_W bits wide. If the signed result is outside [-2^(QUOT_W-1), 2^(QUOT_W-1)-1], it clamps to the bound and overflow=1. Remainder is unaffected.
- Divisor = 0: same latency. quotient = 2^(QUOT_W-1)-1 if dividend ≥ 0, else -2^(QUOT_W-1). remainder=0, div_zero=1, overflow=0.
- Dividend = -2^(DIVIDEND_W-1): its magnitude is held in DIVIDEND_W bits unsigned, so there is no wrap.
- reset asserted mid-operation aborts immediately to reset values. There is no partial result and no done.

Optional Feature:
- NETWORK_DIV_ROUND_EN defined: the quotient rounds half away from zero. If 2*|rem| ≥ divisor, the magnitude increments by 1 before the sign is applied and before saturation. The remainder output still reports the truncated remainder. Latency is unchanged.
- Undefined: truncate toward zero as specified above.

Test Plan:
- dividend=1000, divisor=7 -> quotient=142, remainder=6, div_zero=0, overflow=0; done exactly 28 enabled edges after start; busy high throughout.
- dividend=-1000, divisor=7 -> quotient=-142, remainder=-6. With NETWORK_DIV_ROUND_EN: 1000/7 -> 143, -1000/7 -> -143, remainder still ±6.
- divisor=0, dividend=5 -> quotient=32767, remainder=0, div_zero=1. Dividend=-5 -> quotient=-32768, same latency.
- dividend=67108863, divisor=1 -> quotient=32767, overflow=1. Dividend=-67108864, divisor=1 -> quotient=-32768, overflow=1. Dividend=-67108864, divisor=2047 -> quotient=-32784 clamps to -32768, overflow=1, remainder=-16.
- ce=0 for 5 cycles during CALC, and a second start pulse while busy -> done 5 cycles later, results identical to the first case, second start ignored.
- reset=0 at the 10th CALC cycle -> all outputs 0 asynchronously, no done. After release, start with 1000/7 -> correct result at the normal latency.
